// File: rtl/msbs_t3_coef_sim2seq_unloader_if.sv
// Bundle for the coefficient-bank unloader: bank load side plus the per-entry
// streaming side toward the Chien-search / root-finder stage.
interface msbs_t3_coef_sim2seq_unloader_if #(
    parameter int GF_LEN     = 10,
    parameter int KEY_EQ_BUF = 8
) ();
    localparam int IDX_W  = (KEY_EQ_BUF > 1) ? $clog2(KEY_EQ_BUF) : 1;
    localparam int BANK_W = GF_LEN * KEY_EQ_BUF * 4;

    logic                  in_load;
    logic [BANK_W-1:0]     in_coef;
    logic [KEY_EQ_BUF-1:0] in_deg2;
    logic [KEY_EQ_BUF-1:0] in_deg3;
    logic                  in_ready;

    logic                  out_load_ready;
    logic                  out_valid;
    logic [GF_LEN-1:0]     out_coef_C;
    logic [GF_LEN-1:0]     out_coef_B;
    logic [GF_LEN-1:0]     out_coef_A;
    logic [GF_LEN-1:0]     out_coef_R;
    logic                  out_deg2;
    logic                  out_deg3;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_first;
    logic                  out_last;
    logic                  out_ovf;

    // Producer / consumer side (key-equation stage and downstream sink).
    modport master (
        output in_load, in_coef, in_deg2, in_deg3, in_ready,
        input  out_load_ready, out_valid, out_coef_C, out_coef_B, out_coef_A,
               out_coef_R, out_deg2, out_deg3, out_idx, out_first, out_last,
               out_ovf
    );

    // Unloader side.
    modport slave (
        input  in_load, in_coef, in_deg2, in_deg3, in_ready,
        output out_load_ready, out_valid, out_coef_C, out_coef_B, out_coef_A,
               out_coef_R, out_deg2, out_deg3, out_idx, out_first, out_last,
               out_ovf
    );
endinterface

// File: rtl/msbs_t3_coef_sim2seq_unloader.sv
// Captures a parallel t=3 mSBS error-locator coefficient bank in one strobe and
// streams it one entry per cycle under valid/ready with first/last markers.
module msbs_t3_coef_sim2seq_unloader #(
    parameter int GF_LEN                    = 10,
    parameter int KEY_EQ_BUF                = 8,
    parameter int EQUATION_COEF_NUMS        = 4,
    parameter int OUT_BUF_SHIFING_DIRECTION = 1
) (
    input  logic clk,
    input  logic in_ctr_Srst,
    input  logic in_ctr_en,
    msbs_t3_coef_sim2seq_unloader_if.slave bus
);
    localparam int IDX_W   = (KEY_EQ_BUF > 1) ? $clog2(KEY_EQ_BUF) : 1;
    localparam int ENTRY_W = GF_LEN * EQUATION_COEF_NUMS;
    localparam int BANK_W  = ENTRY_W * KEY_EQ_BUF;

    localparam logic [IDX_W-1:0] FIRST_IDX =
        (OUT_BUF_SHIFING_DIRECTION != 0) ? '0 : IDX_W'(KEY_EQ_BUF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX =
        (OUT_BUF_SHIFING_DIRECTION != 0) ? IDX_W'(KEY_EQ_BUF - 1) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [KEY_EQ_BUF-1:0] deg2_q, deg2_d;
    logic [KEY_EQ_BUF-1:0] deg3_q, deg3_d;
    logic                  ovf_q, ovf_d;

    logic [ENTRY_W-1:0]    coef_q, coef_d;
    logic                  odeg2_q, odeg2_d;
    logic                  odeg3_q, odeg3_d;
    logic [IDX_W-1:0]      oidx_q, oidx_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;

    logic                  load_ready;
    logic                  fire;
    logic                  load_ok;

    function automatic logic [ENTRY_W-1:0] entry_at(
        input logic [BANK_W-1:0] bank,
        input logic [IDX_W-1:0]  idx
    );
        return bank[int'(idx) * ENTRY_W +: ENTRY_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx);
        if (OUT_BUF_SHIFING_DIRECTION != 0) begin
            return idx + IDX_W'(1);
        end
        return idx - IDX_W'(1);
    endfunction

    // last_q is only ever set in EMIT, so it marks the final beat directly.
    assign load_ready = (state_q == IDLE) || (last_q && bus.in_ready);
    assign fire       = (state_q == EMIT) && bus.in_ready;
    assign load_ok    = bus.in_load && load_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        deg2_d  = deg2_q;
        deg3_d  = deg3_q;
        ovf_d   = 1'b0;

        if (in_ctr_en) begin
            ovf_d = bus.in_load && !load_ready;
            unique case (state_q)
                IDLE: begin
                    if (load_ok) begin
                        state_d = EMIT;
                        idx_d   = FIRST_IDX;
                        bank_d  = bus.in_coef;
                        deg2_d  = bus.in_deg2;
                        deg3_d  = bus.in_deg3;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        if (!last_q) begin
                            idx_d = idx_step(idx_q);
                        end else if (load_ok) begin
                            // Back-to-back bank: recapture on the final beat.
                            idx_d  = FIRST_IDX;
                            bank_d = bus.in_coef;
                            deg2_d = bus.in_deg2;
                            deg3_d = bus.in_deg3;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output registers track the next shadow/index so data never flows
    // combinationally from in_coef to the outputs.
    always_comb begin
        coef_d  = entry_at(bank_d, idx_d);
        odeg2_d = deg2_d[idx_d];
        odeg3_d = deg3_d[idx_d];
        oidx_d  = idx_d;
        first_d = (state_d == EMIT) && (idx_d == FIRST_IDX);
        last_d  = (state_d == EMIT) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            bank_q  <= '0;
            deg2_q  <= '0;
            deg3_q  <= '0;
            ovf_q   <= 1'b0;
            coef_q  <= '0;
            odeg2_q <= 1'b0;
            odeg3_q <= 1'b0;
            oidx_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
            deg2_q  <= deg2_d;
            deg3_q  <= deg3_d;
            ovf_q   <= ovf_d;
            coef_q  <= coef_d;
            odeg2_q <= odeg2_d;
            odeg3_q <= odeg3_d;
            oidx_q  <= oidx_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign bus.out_load_ready = load_ready;
    assign bus.out_valid      = (state_q == EMIT);
    assign bus.out_coef_C     = coef_q[ENTRY_W-1 -: GF_LEN];
    assign bus.out_coef_B     = coef_q[ENTRY_W-GF_LEN-1 -: GF_LEN];
    assign bus.out_coef_A     = coef_q[2*GF_LEN-1 -: GF_LEN];
    assign bus.out_coef_R     = coef_q[GF_LEN-1:0];
    assign bus.out_deg2       = odeg2_q;
    assign bus.out_deg3       = odeg3_q;
    assign bus.out_idx        = oidx_q;
    assign bus.out_first      = first_q;
    assign bus.out_last       = last_q;
    assign bus.out_ovf        = ovf_q;

endmodule

// File: tb/tb_msbs_t3_coef_sim2seq_unloader.sv
// Directed bench for the coefficient-bank unloader: forward and reverse units
// driven with hand-built banks, checked beat by beat with immediate assertions.
module tb_msbs_t3_coef_sim2seq_unloader;
    logic clk = 1'b0;
    logic rst;
    logic en;
    int   nvec  = 0;
    int   nmiss = 0;

    always #5 clk = ~clk;

    msbs_t3_coef_sim2seq_unloader_if #(.GF_LEN(10), .KEY_EQ_BUF(8)) f ();
    msbs_t3_coef_sim2seq_unloader_if #(.GF_LEN(10), .KEY_EQ_BUF(8)) r ();

    msbs_t3_coef_sim2seq_unloader #(
        .GF_LEN(10), .KEY_EQ_BUF(8), .EQUATION_COEF_NUMS(4),
        .OUT_BUF_SHIFING_DIRECTION(1)
    ) u_fwd (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .bus(f)
    );

    msbs_t3_coef_sim2seq_unloader #(
        .GF_LEN(10), .KEY_EQ_BUF(8), .EQUATION_COEF_NUMS(4),
        .OUT_BUF_SHIFING_DIRECTION(0)
    ) u_rev (
        .clk(clk), .in_ctr_Srst(rst), .in_ctr_en(en), .bus(r)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmiss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry i: C=0x100+i, B=0x200+i, A=0x300+i, R=rbase+i.
    function automatic logic [319:0] mk_bank(input int rbase);
        logic [319:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i*40 +: 40] = {10'(256 + i), 10'(512 + i), 10'(768 + i), 10'(rbase + i)};
        end
        return b;
    endfunction

    // Forward unit beat at index k of a bank with the given R base.
    task automatic chk_f(input int k, input int rbase);
        chk("f_valid", f.out_valid, 1);
        chk("f_idx",   f.out_idx, k);
        chk("f_C",     f.out_coef_C, 256 + k);
        chk("f_B",     f.out_coef_B, 512 + k);
        chk("f_A",     f.out_coef_A, 768 + k);
        chk("f_R",     f.out_coef_R, rbase + k);
        chk("f_deg2",  f.out_deg2, (k >= 4) ? 1 : 0);
        chk("f_deg3",  f.out_deg3, (k < 4) ? 1 : 0);
        chk("f_first", f.out_first, (k == 0) ? 1 : 0);
        chk("f_last",  f.out_last, (k == 7) ? 1 : 0);
    endtask

    logic [319:0] bank_a;
    logic [319:0] bank_b;
    logic [3:0]   pat;
    logic         rdy;
    int           ei;
    int           cyc;
    int           kr;

    initial begin
        bank_a = mk_bank(0);
        bank_b = mk_bank(32'h3F0);
        pat    = 4'b1001;
        rst    = 1'b1;
        en     = 1'b1;
        f.in_load = 1'b0; f.in_coef = '0; f.in_deg2 = '0; f.in_deg3 = '0; f.in_ready = 1'b0;
        r.in_load = 1'b0; r.in_coef = '0; r.in_deg2 = '0; r.in_deg3 = '0; r.in_ready = 1'b0;
        step();
        step();

        chk("rst_valid", f.out_valid, 0);
        chk("rst_C",     f.out_coef_C, 0);
        chk("rst_R",     f.out_coef_R, 0);
        chk("rst_deg2",  f.out_deg2, 0);
        chk("rst_idx",   f.out_idx, 0);
        chk("rst_first", f.out_first, 0);
        chk("rst_last",  f.out_last, 0);
        chk("rst_ovf",   f.out_ovf, 0);
        chk("rst_lrdy",  f.out_load_ready, 1);
        chk("rst_rvalid", r.out_valid, 0);
        chk("rst_ridx",  r.out_idx, 0);
        rst = 1'b0;

        // Forward and reverse unload of the same bank.
        f.in_coef = bank_a; f.in_deg2 = 8'hF0; f.in_deg3 = 8'h0F; f.in_ready = 1'b1; f.in_load = 1'b1;
        r.in_coef = bank_a; r.in_deg2 = 8'hF0; r.in_deg3 = 8'h0F; r.in_ready = 1'b1; r.in_load = 1'b1;
        step();
        f.in_load = 1'b0;
        r.in_load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_f(k, 0);
            kr = 7 - k;
            chk("r_valid", r.out_valid, 1);
            chk("r_idx",   r.out_idx, kr);
            chk("r_R",     r.out_coef_R, kr);
            chk("r_C",     r.out_coef_C, 256 + kr);
            chk("r_deg2",  r.out_deg2, (kr >= 4) ? 1 : 0);
            chk("r_first", r.out_first, (kr == 7) ? 1 : 0);
            chk("r_last",  r.out_last, (kr == 0) ? 1 : 0);
            step();
        end
        chk("fwd_idle_valid", f.out_valid, 0);
        chk("rev_idle_valid", r.out_valid, 0);
        chk("fwd_idle_lrdy",  f.out_load_ready, 1);

        // Backpressure: ready follows 1,0,0,1 per cycle.
        f.in_load = 1'b1;
        step();
        f.in_load = 1'b0;
        ei  = 0;
        cyc = 0;
        while (ei < 8 && cyc < 40) begin
            chk("bp_valid", f.out_valid, 1);
            chk("bp_idx",   f.out_idx, ei);
            chk("bp_R",     f.out_coef_R, ei);
            chk("bp_C",     f.out_coef_C, 256 + ei);
            rdy = pat[cyc % 4];
            f.in_ready = rdy;
            step();
            if (rdy) ei++;
            cyc++;
        end
        chk("bp_cycles", cyc, 16);
        chk("bp_idle",   f.out_valid, 0);
        f.in_ready = 1'b1;

        // Back-to-back banks: reload on the last-beat fire.
        f.in_coef = bank_a;
        f.in_load = 1'b1;
        step();
        f.in_load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_f(k, 0);
            if (k == 7) begin
                f.in_coef = bank_b;
                f.in_load = 1'b1;
                chk("b2b_lrdy", f.out_load_ready, 1);
            end
            step();
        end
        f.in_load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_f(k, 32'h3F0);
            chk("b2b_ovf", f.out_ovf, 0);
            step();
        end
        chk("b2b_idle", f.out_valid, 0);

        // Overflow on a mid-bank load, then a 5-cycle enable freeze.
        f.in_coef = bank_a;
        f.in_load = 1'b1;
        step();
        f.in_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_f(k, 0);
            step();
        end
        chk_f(3, 0);
        f.in_coef = bank_b;
        f.in_load = 1'b1;
        chk("ovf_lrdy", f.out_load_ready, 0);
        step();
        f.in_load = 1'b0;
        chk("ovf_pulse", f.out_ovf, 1);
        chk_f(4, 0);
        step();
        chk("ovf_clear", f.out_ovf, 0);
        chk_f(5, 0);
        en = 1'b0;
        f.in_load = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_f(5, 0);
            chk("frz_ovf", f.out_ovf, 0);
        end
        en = 1'b1;
        f.in_load = 1'b0;
        step();
        chk_f(6, 0);
        chk("res_ovf", f.out_ovf, 0);
        step();
        chk_f(7, 0);
        step();
        chk("ovf_idle", f.out_valid, 0);

        // Reset mid-bank, then a fresh load restarts at index 0.
        f.in_coef = bank_a;
        f.in_load = 1'b1;
        step();
        f.in_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_f(k, 0);
            step();
        end
        chk_f(4, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", f.out_valid, 0);
        chk("mr_C",     f.out_coef_C, 0);
        chk("mr_B",     f.out_coef_B, 0);
        chk("mr_A",     f.out_coef_A, 0);
        chk("mr_R",     f.out_coef_R, 0);
        chk("mr_deg2",  f.out_deg2, 0);
        chk("mr_deg3",  f.out_deg3, 0);
        chk("mr_idx",   f.out_idx, 0);
        chk("mr_first", f.out_first, 0);
        chk("mr_last",  f.out_last, 0);
        chk("mr_ovf",   f.out_ovf, 0);
        f.in_coef = bank_b;
        f.in_load = 1'b1;
        step();
        f.in_load = 1'b0;
        chk_f(0, 32'h3F0);
        for (int c = 0; c < 8; c++) step();
        chk("mr_idle", f.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end
endmodule
